// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR filter: FSM states,
// the default low-pass coefficient table and the output rounding/saturation helper.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

  localparam int DEFAULT_TAPS = 29;
  localparam int DEFAULT_AW   = 5;

  // Symmetric Q1.15 low-pass response, centre tap at index 14
  localparam int DEFAULT_COEFFS [DEFAULT_TAPS] = '{
    -1, -2, -3, -5, -6, -5, 0, 10, 25, 45, 67, 90, 110, 123, 128,
    123, 110, 90, 67, 45, 25, 10, 0, -5, -6, -5, -3, -2, -1
  };

  typedef struct packed {
    logic [63:0] value;
    logic        sat;
  } round_t;

  function automatic int default_coeff(input int k);
    if (k >= 0 && k < DEFAULT_TAPS) return DEFAULT_COEFFS[k[DEFAULT_AW-1:0]];
    return 0;
  endfunction

  // Round half up, drop the fractional bits, then clip to a signed 'width'-bit range
  function automatic round_t round_sat(input logic signed [63:0] acc,
                                       input int frac_bits,
                                       input int width);
    round_t res;
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted   = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    max_v     = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v     = -(64'sd1 <<< (width - 1));
    res.sat   = 1'b0;
    res.value = shifted;
    if (shifted > max_v) begin
      res.value = max_v;
      res.sat   = 1'b1;
    end else if (shifted < min_v) begin
      res.value = min_v;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file: loads the package defaults on reset, one write
// port, and an asynchronous read addressed by the current tap index.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 29
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           wr_en,
  input  logic [$clog2(TAPS)-1:0]        wr_addr,
  input  logic signed [COEFF_WIDTH-1:0]  wr_data,
  input  logic [$clog2(TAPS)-1:0]        rd_addr,
  output logic signed [COEFF_WIDTH-1:0]  rd_data
);

  localparam int AW = $clog2(TAPS);

  logic signed [COEFF_WIDTH-1:0] coeffs [TAPS];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < TAPS; k++) begin
        coeffs[AW'(k)] <= COEFF_WIDTH'(default_coeff(k));
      end
    end else if (wr_en && (int'(wr_addr) < TAPS)) begin
      coeffs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = coeffs[rd_addr];

endmodule

// File: rtl/fir_filter_mac.sv
// Single-multiplier FIR filter: one sample is accepted in IDLE, then TAPS
// multiply-accumulate cycles walk the circular delay line before one rounding cycle.
module fir_filter_mac
  import fir_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 29,
  parameter int FRAC_BITS   = 15
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic signed [WIDTH-1:0]        audio_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  input  logic                           coeff_wr_en,
  input  logic [$clog2(TAPS)-1:0]        coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0]  coeff_data,
  output logic signed [WIDTH-1:0]        filtered_audio,
  output logic                           data_ready,
  output logic                           sat_out
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = WIDTH + COEFF_WIDTH + AW;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t state, next_state;
  logic accept;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tap;
  logic signed [WIDTH-1:0]       delay_line [TAPS];
  logic signed [WIDTH-1:0]       tap_sample;
  logic signed [COEFF_WIDTH-1:0] tap_coeff;
  logic signed [PROD_W-1:0]      product;
  logic signed [ACC_W-1:0]       acc;
  round_t rounded;

  fir_coeff_bank #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .TAPS        (TAPS)
  ) u_coeff_bank (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (coeff_wr_en && (state == IDLE)),
    .wr_addr (coeff_addr),
    .wr_data (coeff_data),
    .rd_addr (tap),
    .rd_data (tap_coeff)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_out  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          accept     = 1'b1;
          next_state = MAC;
        end
      end
      MAC:     if (tap == LAST) next_state = ROUND;
      ROUND:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign tap_sample = delay_line[rd_ptr];
  assign product    = $signed(PROD_W'(tap_sample)) * $signed(PROD_W'(tap_coeff));
  assign rounded    = round_sat(64'(acc), FRAC_BITS, WIDTH);

  // rd_ptr starts on the newest sample and walks backwards in time, one tap per cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < TAPS; i++) delay_line[AW'(i)] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tap            <= '0;
      acc            <= '0;
      filtered_audio <= '0;
      data_ready     <= 1'b0;
      sat_out        <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            delay_line[wr_ptr] <= audio_in;
            rd_ptr             <= wr_ptr;
            wr_ptr             <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            acc                <= '0;
            tap                <= '0;
          end
        end
        MAC: begin
          acc    <= acc + ACC_W'(product);
          tap    <= tap + 1'b1;
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
        end
        ROUND: begin
          filtered_audio <= rounded.value[WIDTH-1:0];
          sat_out        <= rounded.sat;
          data_ready     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
// Randomised self-checking bench for fir_filter_mac against a queue-based
// convolution model of the filter equation with round-half-up and clipping.
module tb_fir_filter_mac;

  localparam int TAPS = 29;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [15:0] audio_in;
  logic               valid_in;
  logic               ready_out;
  logic               coeff_wr_en;
  logic [4:0]         coeff_addr;
  logic signed [15:0] coeff_data;
  logic signed [15:0] filtered_audio;
  logic               data_ready;
  logic               sat_out;

  int checks = 0;
  int errors = 0;

  int model_coeff [TAPS];
  int hist [$];

  const int default_table [TAPS] = '{
    -1, -2, -3, -5, -6, -5, 0, 10, 25, 45, 67, 90, 110, 123, 128,
    123, 110, 90, 67, 45, 25, 10, 0, -5, -6, -5, -3, -2, -1
  };

  fir_filter_mac dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .audio_in       (audio_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .coeff_wr_en    (coeff_wr_en),
    .coeff_addr     (coeff_addr),
    .coeff_data     (coeff_data),
    .filtered_audio (filtered_audio),
    .data_ready     (data_ready),
    .sat_out        (sat_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input longint got, input longint expected);
    checks++;
    if (got != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) model_coeff[k] = default_table[k];
    hist.delete();
    for (int k = 0; k < TAPS; k++) hist.push_back(0);
  endtask

  // y = sum coeff[k] * x[n-k], then round half up by 2^15 and clip to 16 bits
  task automatic model_step(input int sample, output int y, output bit sat);
    longint sum;
    hist.push_front(sample);
    void'(hist.pop_back());
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += longint'(model_coeff[k]) * longint'(hist[k]);
    sum = (sum + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (sum > 32767) begin
      sum = 32767;
      sat = 1'b1;
    end else if (sum < -32768) begin
      sum = -32768;
      sat = 1'b1;
    end
    y = int'(sum);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic write_coeff(input logic [4:0] addr, input logic signed [15:0] data);
    @(negedge clk_in);
    coeff_wr_en = 1'b1;
    coeff_addr  = addr;
    coeff_data  = data;
    @(posedge clk_in);
    #1;
    coeff_wr_en = 1'b0;
    if (addr < TAPS) model_coeff[addr] = data;
  endtask

  task automatic applyStimulus(input logic signed [15:0] sample, input bit poke_busy,
                               input bit with_coeff, input logic [4:0] caddr,
                               input logic signed [15:0] cdata);
    int lat;
    int exp_y;
    bit exp_sat;
    @(negedge clk_in);
    checkOutput("ready_idle", ready_out, 1);
    audio_in = sample;
    valid_in = 1'b1;
    if (with_coeff) begin
      coeff_wr_en = 1'b1;
      coeff_addr  = caddr;
      coeff_data  = cdata;
      if (caddr < TAPS) model_coeff[caddr] = cdata;
    end
    @(posedge clk_in);
    #1;
    valid_in    = 1'b0;
    coeff_wr_en = 1'b0;
    model_step(sample, exp_y, exp_sat);
    lat = 1;
    checkOutput("dr_low_after_accept", data_ready, 0);
    while (!data_ready && lat < 100) begin
      if (poke_busy && lat == 3) begin
        checkOutput("ready_busy", ready_out, 0);
        valid_in    = 1'b1;
        audio_in    = ~sample;
        coeff_wr_en = 1'b1;
        coeff_addr  = 5'd0;
        coeff_data  = 16'sh7FFF;
      end else begin
        valid_in    = 1'b0;
        coeff_wr_en = 1'b0;
      end
      @(posedge clk_in);
      #1;
      lat++;
    end
    valid_in    = 1'b0;
    coeff_wr_en = 1'b0;
    checkOutput("latency", lat, TAPS + 2);
    checkOutput("filtered_audio", filtered_audio, exp_y);
    checkOutput("sat_out", sat_out, exp_sat);
  endtask

  initial begin
    int dr_seen;
    rst_in      = 1'b1;
    audio_in    = '0;
    valid_in    = 1'b0;
    coeff_wr_en = 1'b0;
    coeff_addr  = '0;
    coeff_data  = '0;
    do_reset();

    #1;
    checkOutput("rst_filtered", filtered_audio, 0);
    checkOutput("rst_data_ready", data_ready, 0);
    checkOutput("rst_sat", sat_out, 0);
    checkOutput("rst_ready", ready_out, 1);

    $display("[TB] unity tap");
    write_coeff(5'd0, 16'sd16384);
    for (int k = 1; k < TAPS; k++) write_coeff(5'(k), 16'sd0);
    applyStimulus(16'sd1000, 1'b0, 1'b0, 5'd0, 16'sd0);
    checkOutput("unity_500", filtered_audio, 500);

    $display("[TB] rounding");
    write_coeff(5'd0, 16'sd1);
    applyStimulus(16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0);
    checkOutput("round_pos", filtered_audio, 1);
    applyStimulus(-16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0);
    checkOutput("round_neg", filtered_audio, 0);

    $display("[TB] saturation");
    for (int k = 0; k < TAPS; k++) write_coeff(5'(k), 16'sd32767);
    for (int i = 0; i < TAPS; i++) applyStimulus(16'sd32767, 1'b0, 1'b0, 5'd0, 16'sd0);
    checkOutput("sat_pos_val", filtered_audio, 32767);
    checkOutput("sat_pos_flag", sat_out, 1);
    for (int i = 0; i < TAPS; i++) applyStimulus(-16'sd32768, 1'b0, 1'b0, 5'd0, 16'sd0);
    checkOutput("sat_neg_val", filtered_audio, -32768);
    checkOutput("sat_neg_flag", sat_out, 1);

    $display("[TB] impulse with default coefficients");
    do_reset();
    applyStimulus(16'sd32767, 1'b0, 1'b0, 5'd0, 16'sd0);
    checkOutput("impulse_0", filtered_audio, default_table[0]);
    for (int i = 1; i < TAPS; i++) begin
      applyStimulus(16'sd0, 1'b0, 1'b0, 5'd0, 16'sd0);
      checkOutput($sformatf("impulse_%0d", i), filtered_audio, default_table[i]);
    end

    $display("[TB] busy drop");
    applyStimulus(16'sd12000, 1'b1, 1'b0, 5'd0, 16'sd0);
    applyStimulus(-16'sd7000, 1'b0, 1'b0, 5'd0, 16'sd0);

    $display("[TB] reset mid-MAC");
    @(negedge clk_in);
    audio_in = 16'sd12345;
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    repeat (8) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    checkOutput("abort_filtered", filtered_audio, 0);
    checkOutput("abort_dr", data_ready, 0);
    checkOutput("abort_sat", sat_out, 0);
    checkOutput("abort_ready", ready_out, 1);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    dr_seen = 0;
    repeat (40) begin
      @(posedge clk_in);
      #1;
      if (data_ready) dr_seen++;
    end
    checkOutput("abort_no_dr", dr_seen, 0);
    applyStimulus(16'sd20000, 1'b0, 1'b0, 5'd0, 16'sd0);

    $display("[TB] random samples and coefficient writes");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_coeff(5'($urandom_range(0, 31)), 16'($urandom));
      applyStimulus(16'($urandom), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                    16'($urandom_range(0, 4095)) - 16'sd2048);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
